// File: rtl/bad_block_table_transfer_pkg.sv
// Shared definitions for the bad-block table path: table geometry, transfer FSM states
// and the CRC-8 (poly 0x07) byte update used when BBT_CRC_EN is defined.
package bad_block_table_transfer_pkg;

  localparam int DEF_BLK_ADDR_W = 12;
  localparam int DEF_NUM_BLOCKS = 4096;
  localparam int DEF_BYTE_W     = 8;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_SEND,
    ST_CRC,
    ST_DONE
  } bbt_state_t;

  // MSB-first CRC-8 step over one byte, init value supplied by the caller.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/bad_block_table_transfer_crc8.sv
// Registered CRC-8 accumulator with synchronous clear and byte enable.
// Only built when BBT_CRC_EN is defined; otherwise this file is empty.
`ifdef BBT_CRC_EN
module bbt_crc8
  import bad_block_table_transfer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] crc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc8_update(crc, data);
    end
  end

endmodule
`endif

// File: rtl/bad_block_table_transfer.sv
// Streams the 1-bit-per-block bad-block RAM to the MCU as LSB-first packed bytes.
// Define BBT_CRC_EN to append a CRC-8 beat after the table.
module bad_block_table_transfer
  import bad_block_table_transfer_pkg::*;
#(
  parameter int BLK_ADDR_W = DEF_BLK_ADDR_W,
  parameter int NUM_BLOCKS = DEF_NUM_BLOCKS,
  parameter int BYTE_W     = DEF_BYTE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_rd_en,
  output logic [BLK_ADDR_W-1:0] ram_rd_addr,
  input  logic                  ram_rd_data,
  output logic [BYTE_W-1:0]     tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_last
);

  localparam int CNT_W = $clog2(BYTE_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_W);
  localparam logic [BLK_ADDR_W:0] LAST_BASE = (BLK_ADDR_W + 1)'(NUM_BLOCKS - BYTE_W);

  bbt_state_t state, state_next;

  // One extra address bit so the table end never aliases back to block 0.
  logic [BLK_ADDR_W:0] base;
  logic [CNT_W-1:0]    cyc;
  logic [BYTE_W-2:0]   shreg;
  logic [BYTE_W-1:0]   byte_q;
  logic                last_byte;

  assign last_byte = (base == LAST_BASE);

`ifdef BBT_CRC_EN
  logic [7:0] crc_value;

  bbt_crc8 u_crc (
    .clk   (clk),
    .rst   (rst),
    .clear (state == ST_IDLE && start),
    .en    (state == ST_SEND && tx_ready),
    .data  (byte_q),
    .crc   (crc_value)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_READ;
      ST_READ: if (cyc == CNT_LAST) state_next = ST_SEND;
      ST_SEND: begin
        if (tx_ready) begin
`ifdef BBT_CRC_EN
          state_next = last_byte ? ST_CRC : ST_READ;
`else
          state_next = last_byte ? ST_DONE : ST_READ;
`endif
        end
      end
      ST_CRC:  if (tx_ready) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Reads are issued for cyc 0..7; each flag returns one cycle later, so the
  // capture for block base+k happens while cyc == k+1.
  always_comb begin
    busy        = (state != ST_IDLE);
    done        = (state == ST_DONE);
    ram_rd_en   = (state == ST_READ) && (cyc < CNT_LAST);
    ram_rd_addr = ram_rd_en ? (base[BLK_ADDR_W-1:0] + BLK_ADDR_W'(cyc)) : '0;
    tx_valid    = (state == ST_SEND) || (state == ST_CRC);
    tx_data     = (state == ST_SEND) ? byte_q : '0;
`ifdef BBT_CRC_EN
    if (state == ST_CRC) tx_data = BYTE_W'(crc_value);
    tx_last     = (state == ST_CRC);
`else
    tx_last     = (state == ST_SEND) && last_byte;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base   <= '0;
      cyc    <= '0;
      shreg  <= '0;
      byte_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            base <= '0;
            cyc  <= '0;
          end
        end
        ST_READ: begin
          if (cyc == CNT_LAST) begin
            byte_q <= {ram_rd_data, shreg};
            cyc    <= '0;
          end else begin
            if (cyc != '0) shreg <= {ram_rd_data, shreg[BYTE_W-2:1]};
            cyc <= cyc + 1'b1;
          end
        end
        ST_SEND: begin
          if (tx_ready && !last_byte) base <= base + (BLK_ADDR_W + 1)'(BYTE_W);
        end
        default: ;
      endcase
    end
  end

endmodule
